// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD controller: FSM state encoding and datapath mux select values.
package gcd_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_CMP  = 3'd2,
    S_SUBX = 3'd3,
    S_SUBY = 3'd4,
    S_DONE = 3'd5,
    S_ERR  = 3'd6
  } gcd_state_t;

  localparam logic SEL_OPERAND = 1'b1;
  localparam logic SEL_DIFF    = 1'b0;

endpackage

// File: rtl/gcd_controller_if.sv
// Control/status bundle between the GCD controller (slave) and its requester plus datapath (master).
// Handshake: start is a 4-phase request; done is held while start stays high and clears after start drops.
interface gcd_controller_if;
  logic start;
  logic eq;
  logic lt;
  logic x_load;
  logic y_load;
  logic x_select;
  logic y_select;
  logic busy;
  logic done;
  logic err;

  modport master (
    output start, eq, lt,
    input  x_load, y_load, x_select, y_select, busy, done, err
  );

  modport slave (
    input  start, eq, lt,
    output x_load, y_load, x_select, y_select, busy, done, err
  );
endinterface

// File: rtl/gcd_iter_counter.sv
// Saturating subtraction-step counter for the GCD watchdog; flags when MAX_ITER steps have been taken.
module gcd_iter_counter #(
  parameter int MAX_ITER = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_clear,
  input  logic                            i_incr,
  output logic                            o_limit,
  output logic [$clog2(MAX_ITER+1)-1:0]   o_count
);
  localparam int CNT_W = $clog2(MAX_ITER + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_ITER);

  logic [CNT_W-1:0] r_count;

  // Saturates at LIMIT so a runaway operation can never wrap back under the threshold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_incr && (r_count != LIMIT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_limit = (r_count == LIMIT);
  assign o_count = r_count;
endmodule

// File: rtl/gcd_controller.sv
// Moore FSM sequencing a subtract-and-compare GCD datapath.
// Optional watchdog (macro GCD_CTRL_WATCHDOG_EN) aborts to ERR after MAX_ITER subtraction steps.
module gcd_controller
  import gcd_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX_ITER = 2**WIDTH
) (
  input  logic                          clk,
  input  logic                          clr,
  gcd_controller_if.slave               ctl,
  output gcd_state_t                    o_dbg_state,
  output logic [$clog2(MAX_ITER+1)-1:0] o_dbg_count
);

  gcd_state_t r_state;
  gcd_state_t w_next;
  logic       r_armed;
  logic       w_limit;

  // r_armed records that start has been seen low, so a level held over from a finished job cannot retrigger.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= S_IDLE;
      r_armed <= 1'b1;
    end else begin
      r_state <= w_next;
      if (!ctl.start)
        r_armed <= 1'b1;
      else if (w_next == S_LOAD)
        r_armed <= 1'b0;
    end
  end

`ifdef GCD_CTRL_WATCHDOG_EN
  gcd_iter_counter #(.MAX_ITER(MAX_ITER)) u_iter (
    .clk     (clk),
    .rst     (clr),
    .i_clear (r_state == S_LOAD),
    .i_incr  ((r_state == S_SUBX) || (r_state == S_SUBY)),
    .o_limit (w_limit),
    .o_count (o_dbg_count)
  );
`else
  assign w_limit     = 1'b0;
  assign o_dbg_count = '0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (ctl.start && r_armed) w_next = S_LOAD;
      S_LOAD: w_next = S_CMP;
      S_CMP: begin
        if (ctl.eq)       w_next = S_DONE;
        else if (w_limit) w_next = S_ERR;
        else if (ctl.lt)  w_next = S_SUBY;
        else              w_next = S_SUBX;
      end
      S_SUBX: w_next = S_CMP;
      S_SUBY: w_next = S_CMP;
      S_DONE: if (!ctl.start) w_next = S_IDLE;
      S_ERR:  if (!ctl.start) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs decode r_state only; no input reaches an output combinationally.
  always_comb begin
    ctl.x_load   = 1'b0;
    ctl.y_load   = 1'b0;
    ctl.x_select = SEL_DIFF;
    ctl.y_select = SEL_DIFF;
    ctl.busy     = 1'b0;
    ctl.done     = 1'b0;
    ctl.err      = 1'b0;
    case (r_state)
      S_LOAD: begin
        ctl.x_load   = 1'b1;
        ctl.y_load   = 1'b1;
        ctl.x_select = SEL_OPERAND;
        ctl.y_select = SEL_OPERAND;
        ctl.busy     = 1'b1;
      end
      S_CMP:  ctl.busy = 1'b1;
      S_SUBX: begin
        ctl.x_load = 1'b1;
        ctl.busy   = 1'b1;
      end
      S_SUBY: begin
        ctl.y_load = 1'b1;
        ctl.busy   = 1'b1;
      end
      S_DONE: ctl.done = 1'b1;
      S_ERR: begin
        ctl.done = 1'b1;
        ctl.err  = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_dbg_state = r_state;

endmodule
